// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative right shifter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - default data width, shift-amount width and per-cycle step
//   - shift-kind constants (logical / arithmetic)
//   - small helpers for step clamping and fill-bit selection
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int SIZE_DEF = 31;  // MSB index of the data path
  localparam int SHW_DEF  = 5;   // width of the shift-amount input
  localparam int STEP_DEF = 4;   // maximum bit positions shifted per cycle

  localparam logic KIND_LOGICAL = 1'b0;
  localparam logic KIND_ARITH   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Smaller of two unsigned values; used to clamp the per-cycle step.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Bit shifted in at the top: the sign for arithmetic, zero for logical.
  function automatic logic fill_bit(input logic kind, input logic msb);
    if (kind == KIND_ARITH) begin
      return msb;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/shift_right_iter_chk.sv
// -----------------------------------------------------------------------------
// shift_right_iter_chk
// Protocol and state checks for shift_right_iter; no functional logic.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   state_i     current FSM state
//   count_i     remaining shift count
//   busy_i      busy output of the shifter
//   done_i      done output of the shifter
// -----------------------------------------------------------------------------
module shift_right_iter_chk
  import shift_pkg::*;
#(
  parameter int SHW = SHW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  input state_e         state_i,
  input logic [SHW-1:0] count_i,
  input logic           busy_i,
  input logic           done_i
);

  // done may only ever appear while the unit reports busy.
  a_done_implies_busy : assert property (@(posedge clk) disable iff (!rst_n)
    done_i |-> busy_i);

  // SHIFT is only entered with work left and left the moment count hits zero.
  a_shift_has_work : assert property (@(posedge clk) disable iff (!rst_n)
    (state_i == ST_SHIFT) |-> (count_i != '0));

  // The unused state encoding is never reached.
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    state_i inside {ST_IDLE, ST_SHIFT, ST_DONE});

endmodule

// File: rtl/shift_right_step.sv
// -----------------------------------------------------------------------------
// shift_right_step
// Combinational right shift of a (size+1)-bit value by 0..STEP positions,
// with the vacated upper bits taken from fill_i.
// Ports:
//   val_i   value to shift
//   k_i     shift distance (0..STEP); larger codes are clamped to STEP
//   fill_i  bit inserted at the top
//   res_o   shifted value
// -----------------------------------------------------------------------------
module shift_right_step #(
  parameter int size = 31,
  parameter int STEP = 4
) (
  input  logic [size:0]              val_i,
  input  logic [$clog2(STEP+1)-1:0]  k_i,
  input  logic                       fill_i,
  output logic [size:0]              res_o
);

  localparam int KW = $clog2(STEP + 1);
  localparam int DW = size + 1;

  logic [KW-1:0]      k_eff_s;
  logic [size+STEP:0] wide_s;

  // Encodings above STEP cannot occur from the parent, but clamp them so the
  // fill region is never exhausted.
  assign k_eff_s = (k_i > KW'(STEP)) ? KW'(STEP) : k_i;

  // Prepend STEP copies of the fill bit so a plain logical shift of the wide
  // vector brings the correct fill into the low DW bits.
  assign wide_s = {{STEP{fill_i}}, val_i};
  assign res_o  = DW'(wide_s >> k_eff_s);

endmodule

// File: rtl/shift_right_iter.sv
// -----------------------------------------------------------------------------
// shift_right_iter
// Multi-cycle iterative right shifter (SRL/SRA/SRLV/SRAV, byte-to-word index).
// Shifts up to STEP positions per cycle under a start/done handshake; a flush
// cancels an in-flight operation.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   flush  synchronous cancel of the in-flight operation (beats start in IDLE)
//   in     operand
//   shamt  unsigned shift amount
//   arith  1 = sign fill, 0 = zero fill
//   busy   high in SHIFT or DONE
//   done   one-cycle completion pulse (suppressed in a flush cycle)
//   out    registered result, held until the next completion
// -----------------------------------------------------------------------------
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int size = SIZE_DEF,
  parameter int SHW  = SHW_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           flush,
  input  logic [size:0]  in,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
  output logic           busy,
  output logic           done,
  output logic [size:0]  out
);

  localparam int KW = $clog2(STEP + 1);

  state_e         state_q,   state_d;
  logic [size:0]  operand_q, operand_d;
  logic [SHW-1:0] count_q,   count_d;
  logic           arith_q,   arith_d;
  logic [size:0]  out_q,     out_d;

  logic [KW-1:0]  k_s;
  logic           fill_s;
  logic [size:0]  shifted_s;
  logic [SHW-1:0] count_rem_s;

  // Per-cycle distance k = min(count, STEP); never exceeds count, so the
  // remaining count cannot underflow.
  assign k_s         = KW'(min_u(32'(count_q), 32'(STEP)));
  assign count_rem_s = count_q - SHW'(k_s);

  // An arithmetic shift preserves the MSB, so operand_q[size] stays equal to
  // the latched sign for the whole operation.
  assign fill_s = fill_bit(arith_q, operand_q[size]);

  shift_right_step #(
    .size (size),
    .STEP (STEP)
  ) u_step (
    .val_i  (operand_q),
    .k_i    (k_s),
    .fill_i (fill_s),
    .res_o  (shifted_s)
  );

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    count_d   = count_q;
    arith_d   = arith_q;
    out_d     = out_q;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (start) begin
          operand_d = in;
          count_d   = shamt;
          arith_d   = arith;
          if (shamt == '0) begin
            out_d   = in;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (flush) begin
          // Cancel: out keeps the previous result.
          state_d = ST_IDLE;
        end else begin
          operand_d = shifted_s;
          count_d   = count_rem_s;
          if (count_rem_s == '0) begin
            out_d   = shifted_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_DONE: begin
        // A start seen here is dropped; it must be re-presented in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      count_q   <= '0;
      arith_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      arith_q   <= arith_d;
      out_q     <= out_d;
    end
  end

  // Outputs decode the state register; flush masks done in the cycle it is
  // raised.
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE) && !flush;
  assign out  = out_q;

  shift_right_iter_chk #(
    .SHW (SHW)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_i (state_q),
    .count_i (count_q),
    .busy_i  (busy),
    .done_i  (done)
  );

endmodule
